// File: rtl/clk_freq_meter_if.sv
`timescale 1ns/1ps
// Control, configuration and result signals of the clock frequency meter.
interface clk_freq_meter_if #(
  parameter int C_CNT_W = 32
);
  logic               I_meas_clk;
  logic               I_start;
  logic [C_CNT_W-1:0] I_gate_cycles;
  logic [C_CNT_W-1:0] I_exp_cnt;
  logic [15:0]        I_tol;
  logic               O_busy;
  logic               O_done;
  logic [C_CNT_W-1:0] O_edge_cnt;
  logic [C_CNT_W-1:0] O_high_cnt;
  logic               O_pass;
  logic               O_stuck;

  modport master (
    output I_meas_clk, I_start, I_gate_cycles, I_exp_cnt, I_tol,
    input  O_busy, O_done, O_edge_cnt, O_high_cnt, O_pass, O_stuck
  );

  modport slave (
    input  I_meas_clk, I_start, I_gate_cycles, I_exp_cnt, I_tol,
    output O_busy, O_done, O_edge_cnt, O_high_cnt, O_pass, O_stuck
  );
endinterface

// File: rtl/clk_freq_meter.sv
`timescale 1ns/1ps
// Counts rising edges and high time of an asynchronous clock over an N-cycle gate window
// and judges the edge count against an expected value with tolerance.
module clk_freq_meter #(
  parameter int C_CNT_W       = 32,
  parameter int C_ARM_TIMEOUT = 65536,
  parameter int C_SYNC_STAGES = 2
) (
  input  logic          I_sys_clk,
  input  logic          I_rst,
  clk_freq_meter_if.slave bus
);
  localparam int                 C_TMO_W = $clog2(C_ARM_TIMEOUT + 1);
  localparam logic [C_CNT_W-1:0] C_SAT   = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_DONE} state_t;

  state_t               state;
  logic [C_SYNC_STAGES-1:0] sync_q;
  logic                 meas_d;
  logic                 meas_s;
  logic                 rise;

  logic [C_CNT_W-1:0]   gate_n;
  logic [C_CNT_W-1:0]   exp_n;
  logic [15:0]          tol_n;
  logic [C_CNT_W-1:0]   gate_cnt;
  logic [C_TMO_W-1:0]   tmo_cnt;
  logic [C_CNT_W-1:0]   edge_acc;
  logic [C_CNT_W-1:0]   high_acc;

  logic                 done_q;
  logic [C_CNT_W-1:0]   edge_q;
  logic [C_CNT_W-1:0]   high_q;
  logic                 pass_q;
  logic                 stuck_q;

  logic [C_CNT_W:0]     diff_raw;
  logic [C_CNT_W:0]     diff_abs;
  logic                 tol_ok;

  assign meas_s = sync_q[C_SYNC_STAGES-1];
  assign rise   = meas_s & ~meas_d;

  // Signed difference one bit wider than the counters, so no count pair can overflow it.
  assign diff_raw = {1'b0, edge_acc} - {1'b0, exp_n};
  assign diff_abs = diff_raw[C_CNT_W] ? -diff_raw : diff_raw;
  assign tol_ok   = (diff_abs <= (C_CNT_W+1)'(tol_n));

  function automatic logic [C_CNT_W-1:0] sat_inc(input logic [C_CNT_W-1:0] v, input logic inc);
    return (inc && (v != C_SAT)) ? v + C_CNT_W'(1) : v;
  endfunction

  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      sync_q <= '0;
      meas_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[C_SYNC_STAGES-2:0], bus.I_meas_clk};
      meas_d <= meas_s;
    end
  end

  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      state    <= S_IDLE;
      gate_n   <= '0;
      exp_n    <= '0;
      tol_n    <= '0;
      gate_cnt <= '0;
      tmo_cnt  <= '0;
      edge_acc <= '0;
      high_acc <= '0;
      done_q   <= 1'b0;
      edge_q   <= '0;
      high_q   <= '0;
      pass_q   <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.I_start) begin
            gate_n   <= bus.I_gate_cycles;
            exp_n    <= bus.I_exp_cnt;
            tol_n    <= bus.I_tol;
            tmo_cnt  <= C_TMO_W'(1);
            gate_cnt <= C_CNT_W'(1);
            edge_acc <= '0;
            high_acc <= '0;
            edge_q   <= '0;
            high_q   <= '0;
            pass_q   <= 1'b0;
            stuck_q  <= 1'b0;
            state    <= (bus.I_gate_cycles == '0) ? S_DONE : S_ARM;
          end
        end
        S_ARM: begin
          // The arming edge only opens the window; it is never counted.
          if (rise) begin
            gate_cnt <= C_CNT_W'(1);
            state    <= S_GATE;
          end else if (tmo_cnt == C_TMO_W'(C_ARM_TIMEOUT)) begin
            stuck_q <= 1'b1;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + C_TMO_W'(1);
          end
        end
        S_GATE: begin
          edge_acc <= sat_inc(edge_acc, rise);
          high_acc <= sat_inc(high_acc, meas_s);
          if (gate_cnt == gate_n) begin
            state <= S_DONE;
          end else begin
            gate_cnt <= gate_cnt + C_CNT_W'(1);
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          edge_q <= edge_acc;
          high_q <= high_acc;
          pass_q <= !stuck_q && tol_ok;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.O_busy     = (state == S_ARM) || (state == S_GATE);
  assign bus.O_done     = done_q;
  assign bus.O_edge_cnt = edge_q;
  assign bus.O_high_cnt = high_q;
  assign bus.O_pass     = pass_q;
  assign bus.O_stuck    = stuck_q;
endmodule
